// File: rtl/uc_pkg.sv
// Shared definitions for the multichannel control unit: FSM state encoding,
// the watchdog-off value and a width helper.
package uc_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ZERA     = 3'd1,
    CONTA    = 3'd2,
    REGISTRA = 3'd3,
    PROXIMO  = 3'd4,
    FIM      = 3'd5
  } estado_t;

  localparam int TIMEOUT_DESLIGADO = 0;

  function automatic int largura_min1(input int valor);
    return (valor > 1) ? $clog2(valor) : 1;
  endfunction

endpackage

// File: rtl/temporizador_timeout.sv
// Saturating up-counter used as the per-channel watchdog; expirou flags the
// last allowed cycle (count == LIMITE-1). LIMITE = 0 means never expires.
module temporizador_timeout #(
  parameter int W      = 8,
  parameter int LIMITE = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expirou
);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      contagem <= '0;
    else if (clear)
      contagem <= '0;
    else if (enable && (contagem != {W{1'b1}}))
      contagem <= contagem + 1'b1;
  end

  generate
    if (LIMITE == 0) begin : g_desligado
      assign expirou = 1'b0;
    end else begin : g_ligado
      assign expirou = (contagem == W'(LIMITE - 1));
    end
  endgenerate

endmodule

// File: rtl/unidade_controle_multicanal.sv
// Sweeps a shared counter datapath over NUM_CH channels (clear, count, register)
// with start/stop handshake, continuous mode, per-channel watchdog and done pulse.
module unidade_controle_multicanal
  import uc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic              modo_continuo,
  input  logic              fim_contador,
  output logic              zera,
  output logic              conta,
  output logic              registra,
  output logic [NUM_CH-1:0] registra_en,
  output logic [CH_W-1:0]   canal,
  output logic              ocupado,
  output logic              pronto,
  output logic [NUM_CH-1:0] erro_timeout
);

  localparam int          TW     = largura_min1(TIMEOUT_CICLOS + 1);
  localparam logic [CH_W-1:0] ULTIMO = CH_W'(NUM_CH - 1);

  estado_t           estado, estado_prox;
  logic [CH_W-1:0]   canal_prox;
  logic [NUM_CH-1:0] erro_prox;
  logic              expirou;

  temporizador_timeout #(
    .W      (TW),
    .LIMITE (TIMEOUT_CICLOS)
  ) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .clear   (estado == ZERA),
    .enable  (estado == CONTA),
    .expirou (expirou)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      canal        <= '0;
      erro_timeout <= '0;
    end else begin
      estado       <= estado_prox;
      canal        <= canal_prox;
      erro_timeout <= erro_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    canal_prox  = canal;
    erro_prox   = erro_timeout;
    // Abort outranks count-complete and timeout; channel and flags are kept.
    if (parar && (estado != OCIOSO)) begin
      estado_prox = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado_prox = ZERA;
            canal_prox  = '0;
            erro_prox   = '0;
          end
        end
        ZERA:     estado_prox = CONTA;
        CONTA: begin
          if (fim_contador) begin
            estado_prox = REGISTRA;
          end else if (expirou) begin
            estado_prox      = PROXIMO;
            erro_prox[canal] = 1'b1;
          end
        end
        REGISTRA: estado_prox = PROXIMO;
        PROXIMO: begin
          if (canal == ULTIMO) begin
            estado_prox = FIM;
          end else begin
            estado_prox = ZERA;
            canal_prox  = canal + 1'b1;
          end
        end
        FIM: begin
          if (modo_continuo) begin
            estado_prox = ZERA;
            canal_prox  = '0;
          end else begin
            estado_prox = OCIOSO;
          end
        end
        default:  estado_prox = OCIOSO;
      endcase
    end
  end

  always_comb begin
    zera     = 1'b0;
    conta    = 1'b0;
    registra = 1'b0;
    pronto   = 1'b0;
    ocupado  = 1'b0;
    case (estado)
      ZERA:     begin zera = 1'b1;     ocupado = 1'b1; end
      CONTA:    begin conta = 1'b1;    ocupado = 1'b1; end
      REGISTRA: begin registra = 1'b1; ocupado = 1'b1; end
      PROXIMO:  ocupado = 1'b1;
      FIM:      begin pronto = 1'b1;   ocupado = 1'b1; end
      default:  ocupado = 1'b0;
    endcase
  end

  assign registra_en = registra ? (NUM_CH'(1) << canal) : '0;

endmodule
